// File: rtl/debug_controller.sv
// Debug command executor: pauses/resumes/resets the MCU core and performs memory and register-file accesses.
// Optional breakpoint support is compiled in when the macro DBG_BREAKPOINT_EN is defined.
module debug_controller #(
    parameter int unsigned PAUSE_TIMEOUT = 1024,
    parameter int unsigned RST_CYCLES    = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    input  logic [3:0]  cmd,
    input  logic [31:0] addr,
    input  logic [31:0] d_in,
    output logic        busy,
    output logic [31:0] d_rd,
    output logic        error,
    output logic        mcu_pause,
    input  logic        mcu_paused,
    output logic        mcu_rst,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        reg_we,
    output logic [4:0]  reg_addr,
    output logic [31:0] reg_wdata,
    input  logic [31:0] reg_rdata,
    input  logic [31:0] mcu_pc
);
    typedef enum logic [3:0] {
        OP_STATUS = 4'h0,
        OP_PAUSE  = 4'h1,
        OP_RESUME = 4'h2,
        OP_RESET  = 4'h3,
        OP_MEM_RD = 4'h4,
        OP_MEM_WR = 4'h5,
        OP_REG_RD = 4'h6,
        OP_REG_WR = 4'h7,
        OP_BP_SET = 4'h8,
        OP_BP_CLR = 4'h9
    } op_t;

    typedef enum logic [2:0] {
        S_IDLE, S_DECODE, S_PAUSE_WAIT, S_MEM_ACC, S_REG_ACC, S_RST_HOLD, S_DONE
    } state_t;

    localparam logic [15:0] TO_LAST  = 16'(PAUSE_TIMEOUT - 1);
    localparam logic [15:0] RST_LAST = 16'(RST_CYCLES - 1);

    state_t      r_state;
    logic [3:0]  r_cmd;
    logic [31:0] r_addr;
    logic [31:0] r_din;
    logic        r_paused_cap;
    logic [15:0] r_cnt;
    logic [31:0] r_d_rd;
    logic        r_error;
    logic        r_mcu_pause;
    logic        r_mcu_rst;
    logic        r_mem_req;
    logic        r_mem_we;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic        r_reg_we;
    logic [4:0]  r_reg_addr;
    logic [31:0] r_reg_wdata;
    logic        w_armed;

`ifdef DBG_BREAKPOINT_EN
    logic [31:0] r_bp;
    logic        r_bp_armed;
    assign w_armed = r_bp_armed;
`else
    logic w_unused_pc;
    assign w_armed     = 1'b0;
    assign w_unused_pc = ^mcu_pc;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_cmd        <= '0;
            r_addr       <= '0;
            r_din        <= '0;
            r_paused_cap <= 1'b0;
            r_cnt        <= '0;
            r_d_rd       <= '0;
            r_error      <= 1'b0;
            r_mcu_pause  <= 1'b0;
            r_mcu_rst    <= 1'b0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_reg_we     <= 1'b0;
            r_reg_addr   <= '0;
            r_reg_wdata  <= '0;
`ifdef DBG_BREAKPOINT_EN
            r_bp         <= '0;
            r_bp_armed   <= 1'b0;
`endif
        end else begin
            r_cnt <= (r_cnt == '1) ? r_cnt : r_cnt + 16'd1;
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_cmd        <= cmd;
                        r_addr       <= addr;
                        r_din        <= d_in;
                        r_paused_cap <= mcu_paused;
                        r_d_rd       <= '0;
                        r_error      <= 1'b0;
                        r_state      <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    // Every timed state is entered from here, so clearing the counter here covers all of them.
                    r_cnt   <= '0;
                    r_state <= S_DONE;
                    case (r_cmd)
                        OP_STATUS: r_d_rd <= {30'b0, w_armed, mcu_paused};
                        OP_PAUSE: begin
                            r_mcu_pause <= 1'b1;
                            r_state     <= S_PAUSE_WAIT;
                        end
                        OP_RESUME: r_mcu_pause <= 1'b0;
                        OP_RESET: begin
                            r_mcu_pause <= 1'b0;
                            r_mcu_rst   <= 1'b1;
                            r_state     <= S_RST_HOLD;
                        end
                        OP_MEM_RD, OP_MEM_WR: begin
                            if (r_paused_cap) begin
                                r_mem_req   <= 1'b1;
                                r_mem_we    <= (r_cmd == OP_MEM_WR);
                                r_mem_addr  <= r_addr;
                                r_mem_wdata <= r_din;
                                r_state     <= S_MEM_ACC;
                            end else begin
                                r_error <= 1'b1;
                            end
                        end
                        OP_REG_RD, OP_REG_WR: begin
                            if (r_paused_cap) begin
                                r_reg_we    <= (r_cmd == OP_REG_WR);
                                r_reg_addr  <= r_addr[4:0];
                                r_reg_wdata <= r_din;
                                r_state     <= S_REG_ACC;
                            end else begin
                                r_error <= 1'b1;
                            end
                        end
`ifdef DBG_BREAKPOINT_EN
                        OP_BP_SET: begin
                            r_bp       <= r_addr;
                            r_bp_armed <= 1'b1;
                        end
                        OP_BP_CLR: r_bp_armed <= 1'b0;
`endif
                        default: r_error <= 1'b1;
                    endcase
                end
                S_PAUSE_WAIT: begin
                    if (mcu_paused) begin
                        r_state <= S_DONE;
                    end else if (r_cnt == TO_LAST) begin
                        r_error <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_MEM_ACC: begin
                    // Ack is checked first so an ack landing on the last allowed cycle still succeeds.
                    if (mem_ack) begin
                        if (!r_mem_we) r_d_rd <= mem_rdata;
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        r_state   <= S_DONE;
                    end else if (r_cnt == TO_LAST) begin
                        r_error   <= 1'b1;
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        r_state   <= S_DONE;
                    end
                end
                S_REG_ACC: begin
                    if (!r_reg_we) r_d_rd <= reg_rdata;
                    r_reg_we <= 1'b0;
                    r_state  <= S_DONE;
                end
                S_RST_HOLD: begin
                    if (r_cnt == RST_LAST) begin
                        r_mcu_rst <= 1'b0;
                        r_state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (!in_valid) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
`ifdef DBG_BREAKPOINT_EN
            if (r_bp_armed && !mcu_paused && (mcu_pc == r_bp)) r_mcu_pause <= 1'b1;
`endif
        end
    end

    assign busy      = ((r_state == S_IDLE) && in_valid) || ((r_state != S_IDLE) && (r_state != S_DONE));
    assign d_rd      = r_d_rd;
    assign error     = r_error;
    assign mcu_pause = r_mcu_pause;
    assign mcu_rst   = r_mcu_rst;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign reg_we    = r_reg_we;
    assign reg_addr  = r_reg_addr;
    assign reg_wdata = r_reg_wdata;
endmodule

// File: tb/tb_debug_controller.sv
// Scoreboard bench for debug_controller: behavioural core, memory and register-file models plus a result predictor.
`timescale 1ns/1ps
module tb_debug_controller;
    localparam int unsigned TO = 1024;
    localparam int unsigned RC = 16;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        in_valid = 1'b0;
    logic [3:0]  cmd = '0;
    logic [31:0] addr = '0;
    logic [31:0] d_in = '0;
    logic        busy;
    logic [31:0] d_rd;
    logic        error;
    logic        mcu_pause;
    logic        mcu_paused;
    logic        mcu_rst;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic        reg_we;
    logic [4:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic [31:0] reg_rdata;
    logic [31:0] mcu_pc = 32'hFFFF_FFFF;

    debug_controller #(.PAUSE_TIMEOUT(TO), .RST_CYCLES(RC)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .cmd(cmd), .addr(addr), .d_in(d_in),
        .busy(busy), .d_rd(d_rd), .error(error), .mcu_pause(mcu_pause), .mcu_paused(mcu_paused),
        .mcu_rst(mcu_rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .reg_we(reg_we),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .mcu_pc(mcu_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic        err;
        int unsigned lat;
        logic        bus;
        int unsigned t0;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    int unsigned cyc = 0;

    logic        core_paused = 1'b0;
    int unsigned pause_delay = 3;
    int unsigned ack_delay   = 1;
    logic [31:0] cur_addr    = '0;
    logic        cur_we      = 1'b0;
    logic [31:0] cur_wdata   = '0;
    logic        armed       = 1'b0;
    logic [31:0] bp          = '0;
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] ref_rf [32];
    logic [31:0] rf [32];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_default(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    function automatic logic [31:0] rf_init(input int unsigned i);
        return 32'h1000_0000 + 32'(i) * 32'h0101;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic finish_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    endtask

    // Register file: x0 reads as zero, writes land on the clock edge where reg_we is high.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) rf[i] <= rf_init(i);
        end else if (reg_we && reg_addr != 5'd0) begin
            rf[reg_addr] <= reg_wdata;
        end
    end
    assign reg_rdata = (reg_addr == 5'd0) ? 32'h0 : rf[reg_addr];

    assign mcu_paused = core_paused;

    initial begin : core
        int unsigned cnt;
        cnt = 0;
        forever begin
            @(posedge clk); #1;
            if (!reset_n || !mcu_pause) begin
                cnt = 0;
                core_paused = 1'b0;
            end else begin
                cnt++;
                if (pause_delay != 0 && cnt >= pause_delay) core_paused = 1'b1;
            end
        end
    end

    initial begin : memory
        logic [31:0] mem_arr [logic [31:0]];
        int unsigned rc;
        logic        stable;
        logic [31:0] a0, w0;
        logic        we0;
        rc = 0; stable = 1'b1; a0 = '0; w0 = '0; we0 = 1'b0;
        forever begin
            @(posedge clk); #1;
            mem_ack   = 1'b0;
            mem_rdata = $urandom();
            if (reset_n && mem_req) begin
                if (rc == 0) begin
                    a0 = mem_addr; w0 = mem_wdata; we0 = mem_we; stable = 1'b1;
                end else if (mem_addr !== a0 || mem_wdata !== w0 || mem_we !== we0) begin
                    stable = 1'b0;
                end
                rc++;
                if (ack_delay != 0 && rc == ack_delay) begin
                    mem_ack = 1'b1;
                    check("mem_addr", mem_addr, cur_addr);
                    check("mem_we", 32'(mem_we), 32'(cur_we));
                    check("mem_stable", 32'(stable), 32'd1);
                    if (mem_we) begin
                        check("mem_wdata", mem_wdata, cur_wdata);
                        mem_arr[mem_addr] = mem_wdata;
                    end else begin
                        mem_rdata = mem_arr.exists(mem_addr) ? mem_arr[mem_addr] : mem_default(mem_addr);
                    end
                end
            end else begin
                rc = 0;
            end
        end
    end

    initial begin : monitor
        logic        prev_busy;
        logic        bus_seen;
        int unsigned rst_len;
        logic        pause_in_rst;
        exp_t        e;
        prev_busy = 1'b0; bus_seen = 1'b0; rst_len = 0; pause_in_rst = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_busy = 1'b0; bus_seen = 1'b0; rst_len = 0; pause_in_rst = 1'b0;
            end else begin
                if (mem_req || reg_we) bus_seen = 1'b1;
                if (mcu_rst) begin
                    rst_len++;
                    if (mcu_pause) pause_in_rst = 1'b1;
                end else if (rst_len != 0) begin
                    check("rst_width", rst_len, RC);
                    check("pause_in_rst", 32'(pause_in_rst), 32'd0);
                    rst_len = 0; pause_in_rst = 1'b0;
                end
                if (in_valid && !busy && prev_busy) begin
                    if (sb.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_done: got completion at cycle %0d expected none", cyc);
                    end else begin
                        e = sb.pop_front();
                        check("d_rd", d_rd, e.d);
                        check("error", 32'(error), 32'(e.err));
                        check("latency", cyc - e.t0, e.lat);
                        check("bus_activity", 32'(bus_seen), 32'(e.bus));
                        check("mem_req_done", 32'(mem_req), 32'd0);
                    end
                    bus_seen = 1'b0;
                end
                prev_busy = busy;
            end
        end
    end

    // Predicts the reply from the command rules, then drives the handshake until busy falls.
    task automatic run(input logic [3:0] c, input logic [31:0] a, input logic [31:0] dn,
                       input int unsigned pd, input int unsigned ad);
        exp_t        e;
        int unsigned n;
        pause_delay = pd;
        ack_delay   = ad;
        e.d = '0; e.err = 1'b0; e.lat = 2; e.bus = 1'b0; e.t0 = cyc;
        case (c)
            4'h0: e.d = {30'b0, armed, core_paused};
            4'h1: begin
                if (core_paused) e.lat = 3;
                else if (pd == 0) begin e.lat = 2 + TO; e.err = 1'b1; end
                else e.lat = 2 + pd;
            end
            4'h2: ;
            4'h3: e.lat = 2 + RC;
            4'h4, 4'h5: begin
                if (!core_paused) e.err = 1'b1;
                else begin
                    e.bus = 1'b1; cur_addr = a; cur_we = (c == 4'h5); cur_wdata = dn;
                    if (ad == 0 || ad > TO) begin e.err = 1'b1; e.lat = 2 + TO; end
                    else begin
                        e.lat = 2 + ad;
                        if (c == 4'h5) ref_mem[a] = dn;
                        else e.d = ref_mem.exists(a) ? ref_mem[a] : mem_default(a);
                    end
                end
            end
            4'h6, 4'h7: begin
                if (!core_paused) e.err = 1'b1;
                else begin
                    e.lat = 3;
                    if (c == 4'h7) begin
                        e.bus = 1'b1;
                        if (a[4:0] != 5'd0) ref_rf[a[4:0]] = dn;
                    end else e.d = ref_rf[a[4:0]];
                end
            end
`ifdef DBG_BREAKPOINT_EN
            4'h8: begin armed = 1'b1; bp = a; end
            4'h9: armed = 1'b0;
`endif
            default: e.err = 1'b1;
        endcase
        sb.push_back(e);
        cmd = c; addr = a; d_in = dn; in_valid = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (busy && n < 3000);
        if (busy) begin
            checks++; errors++;
            $display("FAIL busy_timeout: got busy=1 after %0d cycles expected 0 (cmd %h)", n, c);
            finish_run();
        end
        repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
        in_valid = 1'b0;
        cmd = 4'($urandom()); addr = $urandom(); d_in = $urandom();
        repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
    endtask

    initial begin : main
        int unsigned n;
        ref_rf[0] = '0;
        for (int i = 1; i < 32; i++) ref_rf[i] = rf_init(i);

        #2 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_d_rd", d_rd, 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_pause", 32'(mcu_pause), 32'd0);
        check("rst_mcu_rst", 32'(mcu_rst), 32'd0);
        check("rst_mem", {mem_req, mem_we, reg_we, reg_addr}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;

        run(4'h4, 32'h100, 32'h0, 3, 1);              // core running: access refused
        run(4'h6, 32'h3, 32'h0, 3, 1);
        run(4'h1, 32'h0, 32'h0, 5, 1);                // pause, 5 cycles to halt
        run(4'h0, 32'h0, 32'h0, 5, 1);
        run(4'h5, 32'h200, 32'hDEAD_BEEF, 5, 3);
        run(4'h4, 32'h200, 32'h0, 5, 2);
        run(4'h4, 32'h300, 32'h0, 5, 1);
        run(4'h7, 32'h5, 32'h1234_5678, 5, 1);
        run(4'h6, 32'hFFFF_FFE5, 32'h0, 5, 1);
        run(4'h7, 32'h0, 32'hFFFF_FFFF, 5, 1);
        run(4'h6, 32'h0, 32'h0, 5, 1);
        run(4'h4, 32'h204, 32'h0, 5, 0);              // no ack: timeout
        run(4'h4, 32'h200, 32'h0, 5, TO);             // ack on the last allowed cycle
        run(4'hF, 32'h0, 32'h0, 5, 1);
        run(4'h8, 32'h40, 32'h0, 5, 1);
        run(4'h9, 32'h40, 32'h0, 5, 1);
        run(4'h3, 32'h0, 32'h0, 5, 1);
        run(4'h0, 32'h0, 32'h0, 5, 1);
        run(4'h1, 32'h0, 32'h0, 0, 1);                // core never halts
        run(4'h2, 32'h0, 32'h0, 2, 1);
        run(4'h1, 32'h0, 32'h0, 1, 1);
        run(4'h1, 32'h0, 32'h0, 1, 1);
        run(4'h2, 32'h0, 32'h0, 2, 1);

`ifdef DBG_BREAKPOINT_EN
        run(4'h8, 32'h40, 32'h0, 2, 1);
        mcu_pc = 32'h40;
        @(posedge clk); #1;
        check("bp_pause", 32'(mcu_pause), 32'd1);
        mcu_pc = 32'hFFFF_FFFF;
        repeat (4) begin @(posedge clk); #1; end
        run(4'h0, 32'h0, 32'h0, 2, 1);
        run(4'h9, 32'h0, 32'h0, 2, 1);
        run(4'h2, 32'h0, 32'h0, 2, 1);
        run(4'h0, 32'h0, 32'h0, 2, 1);
`else
        mcu_pc = 32'h40;
        @(posedge clk); #1;
        check("no_bp_pause", 32'(mcu_pause), 32'd0);
        mcu_pc = 32'hFFFF_FFFF;
`endif

        for (int i = 0; i < 80; i++) begin
            logic [3:0]  c;
            logic [31:0] a;
            c = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 7));
            a = $urandom();
            if (c == 4'h4 || c == 4'h5) a = 32'h1000 + 32'($urandom_range(0, 7)) * 4;
            if (c == 4'h8) a = a & 32'hFFFF_FFF0;
            run(c, a, $urandom(), $urandom_range(1, 6), $urandom_range(1, 6));
        end

        // Reset asserted in the middle of the core reset pulse.
        cmd = 4'h3; addr = '0; d_in = '0; in_valid = 1'b1;
        n = 0;
        while (!mcu_rst && n < 50) begin @(posedge clk); #1; n++; end
        check("abort_rst_started", 32'(mcu_rst), 32'd1);
        repeat (5) @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        check("abort_mcu_rst", 32'(mcu_rst), 32'd0);
        check("abort_pause", 32'(mcu_pause), 32'd0);
        check("abort_mem_req", 32'(mem_req), 32'd0);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        armed = 1'b0;
        @(posedge clk); #1;
        run(4'h0, 32'h0, 32'h0, 3, 1);
        run(4'h2, 32'h0, 32'h0, 3, 1);

        check("sb_drained", sb.size(), 32'd0);
        finish_run();
    end

    initial begin : watchdog
        #2_000_000;
        checks++; errors++;
        $display("FAIL watchdog: got no finish by %0t expected earlier", $time);
        finish_run();
    end
endmodule
